shift_lr_burst: RTL and testbench

Parametrised bidirectional shift register. It generalises the fixed 8-bit left/right serial shifter to:
- WIDTH bits.
- Parallel load and parallel readout.
- Rotate mode.
- Multi-bit burst shifts run by an internal counter, with a busy/done handshake.

It sits between serial links and parallel datapaths and is used as a SER/DES or a barrel-style shifter.

---
 rtl/shift_lr_burst.sv | 117 +++++++++++
 tb/tb_shift_lr_burst.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/shift_lr_burst.sv
// WIDTH-bit left/right shift register with parallel load, rotate and counted burst shifts.
// Optional sign-extending right shift is enabled by defining SHIFT_LR_ARITH_EN.
module shift_lr_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic             dir,
  input  logic             rotate,
  input  logic             arith,
  input  logic [CNT_W-1:0] count,
  input  logic             si,
  output logic [WIDTH-1:0] q,
  output logic             sol,
  output logic             sor,
  output logic             busy,
  output logic             done
);

  typedef enum logic {StIdle, StShift} state_e;

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_q, w_q_d;
  logic [CNT_W-1:0]   r_rem, w_rem_d;
  logic               r_dir, w_dir_d;
  logic               r_rot, w_rot_d;
  logic               r_arith, w_arith_d;
  logic               r_done, w_done_d;

  logic [CNT_W-1:0]   w_n;
  logic               w_fill;
  logic [WIDTH-1:0]   w_shifted;

  // Requests longer than the register are clamped to a full-width shift.
  assign w_n = (count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : count;

  always_comb begin
    w_fill = r_dir ? (r_rot ? r_q[0] : si) : (r_rot ? r_q[WIDTH-1] : si);
`ifdef SHIFT_LR_ARITH_EN
    if (r_dir && r_arith) w_fill = r_q[WIDTH-1];
`endif
  end

`ifndef SHIFT_LR_ARITH_EN
  logic w_unused_arith;
  assign w_unused_arith = r_arith;
`endif

  assign w_shifted = r_dir ? {w_fill, r_q[WIDTH-1:1]} : {r_q[WIDTH-2:0], w_fill};

  always_comb begin
    w_state_d = r_state;
    w_q_d     = r_q;
    w_rem_d   = r_rem;
    w_dir_d   = r_dir;
    w_rot_d   = r_rot;
    w_arith_d = r_arith;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (load) begin
          w_q_d = pdata;
        end else if (start) begin
          w_dir_d   = dir;
          w_rot_d   = rotate;
          w_arith_d = arith;
          if (w_n == '0) begin
            w_done_d = 1'b1;
          end else begin
            w_rem_d   = w_n;
            w_state_d = StShift;
          end
        end
      end
      StShift: begin
        w_q_d   = w_shifted;
        w_rem_d = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_q     <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
      r_rot   <= 1'b0;
      r_arith <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_q     <= w_q_d;
      r_rem   <= w_rem_d;
      r_dir   <= w_dir_d;
      r_rot   <= w_rot_d;
      r_arith <= w_arith_d;
      r_done  <= w_done_d;
    end
  end

  assign q    = r_q;
  assign sol  = r_q[WIDTH-1];
  assign sor  = r_q[0];
  assign busy = (r_state == StShift);
  assign done = r_done;

endmodule

// File: tb/tb_shift_lr_burst.sv
// Self-checking bench for shift_lr_burst (WIDTH=8): directed cases plus randomized bursts
// compared against a transaction-level reference model.
module tb_shift_lr_burst;

  logic       clk, rst_n, load, start, dir, rotate, arith, si;
  logic [7:0] pdata;
  logic [3:0] count;
  logic [7:0] q;
  logic       sol, sor, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] m_q;

  shift_lr_burst #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .pdata(pdata), .start(start), .dir(dir),
    .rotate(rotate), .arith(arith), .count(count), .si(si), .q(q), .sol(sol), .sor(sor),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-bit shift computed with integer arithmetic.
  function automatic logic [7:0] ref_shift(input logic [7:0] v, input bit d, input bit r,
                                           input bit a, input bit s);
    int x, fill;
    x = int'(v);
    if (!d) begin
      fill = r ? (x / 128) : int'(s);
      return 8'(((x * 2) % 256) + fill);
    end
    fill = r ? (x % 2) : int'(s);
`ifdef SHIFT_LR_ARITH_EN
    if (a) fill = x / 128;
`else
    if (a) fill = fill;
`endif
    return 8'((x / 2) + fill * 128);
  endfunction

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; start = 1'b0; pdata = v;
    tick();
    load = 1'b0;
    m_q = v;
    check_eq("load_q", q, m_q);
    check_eq("load_busy", busy, 0);
  endtask

  // si_fix < 0 means random serial input; junk drives random load/start during the burst.
  task automatic do_burst(input bit d, input bit r, input bit a, input int cnt, input int si_fix,
                          input bit junk);
    int n;
    bit s;
    start = 1'b1; load = 1'b0; dir = d; rotate = r; arith = a; count = 4'(cnt);
    pdata = 8'($urandom);
    tick();
    start = 1'b0;
    n = (cnt > 8) ? 8 : cnt;
    if (n == 0) begin
      check_eq("zero_done", done, 1);
      check_eq("zero_busy", busy, 0);
      check_eq("zero_q", q, m_q);
      return;
    end
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    check_eq("start_q", q, m_q);
    for (int k = 0; k < n; k++) begin
      s = (si_fix < 0) ? 1'($urandom) : 1'(si_fix);
      si = s;
      dir = 1'($urandom); rotate = 1'($urandom); arith = 1'($urandom);
      if (junk) begin
        load = 1'($urandom); start = 1'($urandom);
        pdata = 8'($urandom); count = 4'($urandom);
      end
      tick();
      m_q = ref_shift(m_q, d, r, a, s);
      check_eq("shift_q", q, m_q);
      check_eq("shift_sol", sol, m_q[7]);
      check_eq("shift_sor", sor, m_q[0]);
      check_eq("shift_busy", busy, (k < n - 1) ? 1 : 0);
      check_eq("shift_done", done, (k < n - 1) ? 0 : 1);
    end
    load = 1'b0; start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; start = 1'b0; dir = 1'b0; rotate = 1'b0; arith = 1'b0;
    si = 1'b0; pdata = '0; count = '0; m_q = '0;
    tick(); tick();
    rst_n = 1'b1;
    check_eq("por_q", q, 0);
    check_eq("por_busy", busy, 0);
    check_eq("por_done", done, 0);

    // Reset clears a loaded value and beats a concurrent load.
    do_load(8'hFF);
    rst_n = 1'b0;
    tick(); tick();
    check_eq("rst_q", q, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    load = 1'b1; pdata = 8'h5A;
    tick();
    check_eq("rst_load_q", q, 0);
    load = 1'b0; rst_n = 1'b1; m_q = '0;

    do_load(8'hA5);
    do_burst(1'b0, 1'b0, 1'b0, 3, 1, 1'b0);
    check_eq("t2_q", q, 8'h2F);
    tick();
    check_eq("t2_done_once", done, 0);

    do_load(8'h81);
    do_burst(1'b1, 1'b1, 1'b0, 1, -1, 1'b0);
    check_eq("t3_q1", q, 8'hC0);
    do_burst(1'b1, 1'b1, 1'b0, 8, -1, 1'b0);
    check_eq("t3_q8", q, 8'hC0);

    do_load(8'hFF);
    do_burst(1'b1, 1'b0, 1'b0, 12, 0, 1'b0);
    check_eq("t4_q", q, 8'h00);
    tick();
    check_eq("t4_done_once", done, 0);

    do_load(8'h6D);
    do_burst(1'b0, 1'b0, 1'b0, 6, -1, 1'b1);
    tick();
    do_burst(1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
    tick();
    check_eq("zero_after_done", done, 0);
    check_eq("zero_after_busy", busy, 0);
    load = 1'b1; start = 1'b1; count = 4'd5; pdata = 8'h3C;
    tick();
    load = 1'b0; start = 1'b0; m_q = 8'h3C;
    check_eq("ld_st_q", q, 8'h3C);
    check_eq("ld_st_busy", busy, 0);
    tick();
    check_eq("ld_st_busy2", busy, 0);
    check_eq("ld_st_done", done, 0);

    // Abort on the second shift edge of a 5-shift burst.
    do_load(8'hB7);
    start = 1'b1; dir = 1'b0; rotate = 1'b0; count = 4'd5; si = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("abort_q", q, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    rst_n = 1'b1;
    tick();
    check_eq("abort_done2", done, 0);
    check_eq("abort_busy2", busy, 0);
    m_q = '0;

`ifdef SHIFT_LR_ARITH_EN
    do_load(8'h90);
    do_burst(1'b1, 1'b0, 1'b1, 2, -1, 1'b0);
    check_eq("arith_q", q, 8'hE4);
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) do_load(8'($urandom));
      do_burst(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)), -1,
               1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        tick();
        check_eq("rnd_idle_done", done, 0);
        check_eq("rnd_idle_q", q, m_q);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
